// File: rtl/reg_file_wb.sv
// Writeback-side register file: two registered read ports,
// write-first bypass, r0 hard-wired to zero.
module reg_file_wb #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  reg_write_ctrl_i,
    input  logic [ADDR_WIDTH-1:0] reg_write_addr_i,
    input  logic [DATA_WIDTH-1:0] reg_write_data_i,
    input  logic [ADDR_WIDTH-1:0] rs_addr_i,
    input  logic [ADDR_WIDTH-1:0] rt_addr_i,
    input  logic                  stall_ctrl_i,
    output logic [DATA_WIDTH-1:0] rs_data_o,
    output logic [DATA_WIDTH-1:0] rt_data_o
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs [DEPTH];
    logic                  wr_en;
    logic                  rs_zero;
    logic                  rt_zero;
    logic                  rs_hit;
    logic                  rt_hit;
    logic [DATA_WIDTH-1:0] rs_next;
    logic [DATA_WIDTH-1:0] rt_next;

    assign wr_en   = reg_write_ctrl_i && (reg_write_addr_i != '0);
    assign rs_zero = (rs_addr_i == '0);
    assign rt_zero = (rt_addr_i == '0);
    assign rs_hit  = wr_en && (reg_write_addr_i == rs_addr_i);
    assign rt_hit  = wr_en && (reg_write_addr_i == rt_addr_i);

    // Writes retire regardless of stall; entry 0 is never written.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en) begin
            regs[reg_write_addr_i] <= reg_write_data_i;
        end
    end

    // rs/rt_hit already exclude address 0, so the arms are exclusive.
    always_comb begin
        rs_next = '0;
        unique case (1'b1)
            rs_zero: rs_next = '0;
            rs_hit:  rs_next = reg_write_data_i;
            default: rs_next = regs[rs_addr_i];
        endcase
    end

    always_comb begin
        rt_next = '0;
        unique case (1'b1)
            rt_zero: rt_next = '0;
            rt_hit:  rt_next = reg_write_data_i;
            default: rt_next = regs[rt_addr_i];
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            rs_data_o <= '0;
            rt_data_o <= '0;
        end else if (!stall_ctrl_i) begin
            rs_data_o <= rs_next;
            rt_data_o <= rt_next;
        end
    end

endmodule

// File: tb/tb_reg_file_wb.sv
// Bench for reg_file_wb: directed vector table, reset sweep,
// then randomized traffic against an array-based reference model.
module tb_reg_file_wb;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic        reg_write_ctrl_i;
    logic [4:0]  reg_write_addr_i;
    logic [31:0] reg_write_data_i;
    logic [4:0]  rs_addr_i;
    logic [4:0]  rt_addr_i;
    logic        stall_ctrl_i;
    logic [31:0] rs_data_o;
    logic [31:0] rt_data_o;

    int errors = 0;
    int checks = 0;

    logic [31:0] mdl [32];
    logic [31:0] m_rs;
    logic [31:0] m_rt;

    typedef struct {
        logic        rst_n;
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [4:0]  ra;
        logic [4:0]  rb;
        logic        st;
        logic [31:0] exp_rs;
        logic [31:0] exp_rt;
    } vec_t;

    vec_t vecs[$];

    reg_file_wb #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(5)
    ) dut (
        .clk_i            (clk_i),
        .rst_n_i          (rst_n_i),
        .reg_write_ctrl_i (reg_write_ctrl_i),
        .reg_write_addr_i (reg_write_addr_i),
        .reg_write_data_i (reg_write_data_i),
        .rs_addr_i        (rs_addr_i),
        .rt_addr_i        (rt_addr_i),
        .stall_ctrl_i     (stall_ctrl_i),
        .rs_data_o        (rs_data_o),
        .rt_data_o        (rt_data_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // Apply one cycle of inputs, then advance the model: the write
    // lands first, so an unstalled read of the same address sees it.
    task automatic step(input logic rst, input logic we,
                        input logic [4:0] wa, input logic [31:0] wd,
                        input logic [4:0] ra, input logic [4:0] rb,
                        input logic st);
        rst_n_i          = rst;
        reg_write_ctrl_i = we;
        reg_write_addr_i = wa;
        reg_write_data_i = wd;
        rs_addr_i        = ra;
        rt_addr_i        = rb;
        stall_ctrl_i     = st;
        @(posedge clk_i);
        #1;
        if (!rst) begin
            for (int i = 0; i < 32; i++) mdl[i] = '0;
            m_rs = '0;
            m_rt = '0;
        end else begin
            if (we && wa != 5'd0) mdl[wa] = wd;
            if (!st) begin
                m_rs = mdl[ra];
                m_rt = mdl[rb];
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mdl[i] = '0;
        m_rs = '0;
        m_rt = '0;

        // rst_n, we, wa, wd, ra, rb, stall, exp_rs, exp_rt
        vecs.push_back('{1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b0, 32'h0, 32'h0});
        vecs.push_back('{1'b1, 1'b1, 5'd5, 32'hDEADBEEF, 5'd0, 5'd0, 1'b0, 32'h0, 32'h0});
        vecs.push_back('{1'b1, 1'b0, 5'd0, 32'h0, 5'd5, 5'd5, 1'b0, 32'hDEADBEEF, 32'hDEADBEEF});
        vecs.push_back('{1'b1, 1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd5, 1'b0, 32'h0, 32'hDEADBEEF});
        vecs.push_back('{1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b0, 32'h0, 32'h0});
        vecs.push_back('{1'b1, 1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0, 1'b0, 32'h0, 32'h0});
        vecs.push_back('{1'b1, 1'b1, 5'd7, 32'h11111111, 5'd0, 5'd0, 1'b0, 32'h0, 32'h0});
        vecs.push_back('{1'b1, 1'b1, 5'd3, 32'h33333333, 5'd7, 5'd0, 1'b0, 32'h11111111, 32'h0});
        vecs.push_back('{1'b1, 1'b1, 5'd7, 32'h22222222, 5'd7, 5'd3, 1'b0, 32'h22222222, 32'h33333333});
        vecs.push_back('{1'b1, 1'b1, 5'd9, 32'hAAAA0000, 5'd9, 5'd0, 1'b0, 32'hAAAA0000, 32'h0});
        vecs.push_back('{1'b1, 1'b1, 5'd9, 32'hBBBB0000, 5'd9, 5'd9, 1'b1, 32'hAAAA0000, 32'h0});
        vecs.push_back('{1'b1, 1'b0, 5'd0, 32'h0, 5'd9, 5'd9, 1'b1, 32'hAAAA0000, 32'h0});
        vecs.push_back('{1'b1, 1'b0, 5'd0, 32'h0, 5'd9, 5'd9, 1'b1, 32'hAAAA0000, 32'h0});
        vecs.push_back('{1'b1, 1'b0, 5'd0, 32'h0, 5'd9, 5'd9, 1'b0, 32'hBBBB0000, 32'hBBBB0000});
        vecs.push_back('{1'b1, 1'b0, 5'd12, 32'h12345678, 5'd12, 5'd12, 1'b0, 32'h0, 32'h0});
        vecs.push_back('{1'b1, 1'b0, 5'd0, 32'h0, 5'd12, 5'd7, 1'b0, 32'h0, 32'h22222222});
        vecs.push_back('{1'b0, 1'b1, 5'd5, 32'hCAFEF00D, 5'd5, 5'd9, 1'b1, 32'h0, 32'h0});
        vecs.push_back('{1'b1, 1'b0, 5'd0, 32'h0, 5'd5, 5'd9, 1'b0, 32'h0, 32'h0});
        vecs.push_back('{1'b1, 1'b0, 5'd0, 32'h0, 5'd7, 5'd3, 1'b0, 32'h0, 32'h0});

        foreach (vecs[i]) begin
            step(vecs[i].rst_n, vecs[i].we, vecs[i].wa, vecs[i].wd,
                 vecs[i].ra, vecs[i].rb, vecs[i].st);
            check($sformatf("vec%0d_rs", i), rs_data_o, vecs[i].exp_rs);
            check($sformatf("vec%0d_rt", i), rt_data_o, vecs[i].exp_rt);
        end

        // Fill r1..r31, reset once, then sweep every address.
        for (int a = 1; a < 32; a++) begin
            step(1'b1, 1'b1, 5'(a), 32'h5A000000 | 32'(a), 5'(a), 5'(a), 1'b0);
        end
        check("prefill_r31", rs_data_o, 32'h5A00001F);
        step(1'b0, 1'b0, 5'd0, 32'h0, 5'd31, 5'd30, 1'b0);
        check("post_reset_rs", rs_data_o, 32'h0);
        check("post_reset_rt", rt_data_o, 32'h0);
        for (int a = 0; a < 32; a++) begin
            step(1'b1, 1'b0, 5'd0, 32'h0, 5'(a), 5'(31 - a), 1'b0);
            check($sformatf("sweep_rs%0d", a), rs_data_o, 32'h0);
            check($sformatf("sweep_rt%0d", 31 - a), rt_data_o, 32'h0);
        end

        // Randomized traffic; reads are biased toward the write address.
        for (int n = 0; n < 2000; n++) begin
            logic        r;
            logic        we;
            logic        st;
            logic [4:0]  wa;
            logic [4:0]  ra;
            logic [4:0]  rb;
            logic [31:0] wd;
            r  = ($urandom_range(0, 99) >= 2);
            we = ($urandom_range(0, 99) < 60);
            st = ($urandom_range(0, 99) < 25);
            wa = 5'($urandom_range(0, 31));
            wd = $urandom;
            ra = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
            rb = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
            step(r, we, wa, wd, ra, rb, st);
            check($sformatf("rand%0d_rs", n), rs_data_o, m_rs);
            check($sformatf("rand%0d_rt", n), rt_data_o, m_rt);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
